// File: rtl/timer_regif_pkg.sv
// Shared constants for the timer APB register interface: register
// addresses, TCR bit positions and the APB handshake state encoding.
package timer_regif_pkg;

  localparam logic [1:0] ADDR_TDR = 2'd0;
  localparam logic [1:0] ADDR_TCR = 2'd1;
  localparam logic [1:0] ADDR_TSR = 2'd2;
  localparam logic [1:0] ADDR_RSV = 2'd3;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_DIR    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/timer_apb_regif_flag.sv
// timer_flag_capture: rising-edge detect on a level status flag, sticky
// capture bit with write-1-to-clear, and a one-cycle clear pulse back to
// the counter datapath. A set and a clear on the same edge leave the bit
// set; the clear pulse is still issued.
module timer_flag_capture (
  input  logic PCLK,
  input  logic RST,
  input  logic flag_in,
  input  logic clr,
  output logic flag_q,
  output logic clr_pulse
);

  logic flag_prev;
  logic rise;

  assign rise = flag_in & ~flag_prev;

  // Edge history, sticky status bit (set has priority) and clear pulse.
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      flag_prev <= 1'b0;
      flag_q    <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      flag_prev <= flag_in;
      clr_pulse <= clr;
      if (rise)
        flag_q <= 1'b1;
      else if (clr)
        flag_q <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_apb_regif.sv
// timer_apb_regif: APB slave front end of the 8-bit timer. Holds TDR/TCR,
// the sticky TSR status (OVF/UNDF) and issues the flag clear pulses.
// Optional macro TIMER_REGIF_PSLVERR_EN: reserved-address accesses and
// writes setting TCR bits outside TCR_WMASK complete with PSLVERR=1 and
// are not committed. Without it PSLVERR is tied low.
//
// state  | meaning
// IDLE   | no transfer; waiting for a setup phase (PSEL=1, PENABLE=0)
// SETUP  | setup phase seen; access phase starts next cycle
// ACCESS | wait states counted; PREADY high for one cycle, commit there
module timer_apb_regif
  import timer_regif_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] TCR_WMASK   = 8'hB3
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              over_flow,
  input  logic              under_flow,
  output logic [7:0]        TDR,
  output logic [7:0]        TCR,
  output logic [1:0]        Clk_SEL,
  output logic              OVF_rst,
  output logic              UNDF_rst
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  apb_state_e state_q, state_d;
  logic [2:0] wait_cnt;
  logic [1:0] addr;
  logic       ready_set;
  logic       commit;
  logic       wr_en;
  logic [7:0] rd_data;
  logic       tsr_ovf, tsr_udf;
  logic       ovf_clr, udf_clr;
  logic       unused_addr_hi;

  assign addr           = PADDR[1:0];
  assign unused_addr_hi = ^PADDR[ADDR_W-1:2];
  assign Clk_SEL        = TCR[TCR_CKS_HI:TCR_CKS_LO];

  // PREADY is registered, so it is scheduled one edge ahead of the cycle it marks.
  assign ready_set = PSEL &&
                     (((state_q == SETUP) && (WAIT_LAST == 3'd0)) ||
                      ((state_q == ACCESS) && !PREADY && (wait_cnt + 3'd1 == WAIT_LAST)));
  assign commit    = (state_q == ACCESS) && PREADY && PSEL;

`ifdef TIMER_REGIF_PSLVERR_EN
  logic err_now;
  assign err_now = (addr == ADDR_RSV) ||
                   (PWRITE && (addr == ADDR_TCR) && |(PWDATA & ~TCR_WMASK));
  assign wr_en   = commit && PWRITE && !err_now;

  // Error response travels with PREADY.
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST)
      PSLVERR <= 1'b0;
    else
      PSLVERR <= ready_set && err_now;
  end
`else
  assign wr_en   = commit && PWRITE;
  assign PSLVERR = 1'b0;
`endif

  assign ovf_clr = wr_en && (addr == ADDR_TSR) && PWDATA[0];
  assign udf_clr = wr_en && (addr == ADDR_TSR) && PWDATA[1];

  // Read mux; reserved address and TSR upper bits read as zero.
  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_TDR: rd_data = TDR;
      ADDR_TCR: rd_data = TCR;
      ADDR_TSR: rd_data = {6'b0, tsr_udf, tsr_ovf};
      default:  rd_data = 8'h00;
    endcase
  end

  // APB handshake state register.
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; PSEL dropping anywhere in a transfer aborts it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (PSEL && !PENABLE) state_d = SETUP;
      SETUP:   state_d = PSEL ? ACCESS : IDLE;
      ACCESS: begin
        if (!PSEL)
          state_d = IDLE;
        else if (PREADY)
          state_d = !PENABLE ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access-phase wait-state counter.
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST)
      wait_cnt <= 3'd0;
    else if (state_q == SETUP)
      wait_cnt <= 3'd0;
    else if ((state_q == ACCESS) && !PREADY)
      wait_cnt <= wait_cnt + 3'd1;
  end

  // Completion strobe and read data capture.
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      PREADY <= 1'b0;
      PRDATA <= 8'h00;
    end else begin
      PREADY <= ready_set;
      if (ready_set && !PWRITE)
        PRDATA <= rd_data;
    end
  end

  // Control register writes, committed in the PREADY cycle.
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      TDR <= 8'h00;
      TCR <= 8'h00;
    end else if (wr_en) begin
      if (addr == ADDR_TDR) TDR <= PWDATA;
      if (addr == ADDR_TCR) TCR <= PWDATA & TCR_WMASK;
    end
  end

  timer_flag_capture u_ovf (
    .PCLK      (PCLK),
    .RST       (RST),
    .flag_in   (over_flow),
    .clr       (ovf_clr),
    .flag_q    (tsr_ovf),
    .clr_pulse (OVF_rst)
  );

  timer_flag_capture u_udf (
    .PCLK      (PCLK),
    .RST       (RST),
    .flag_in   (under_flow),
    .clr       (udf_clr),
    .flag_q    (tsr_udf),
    .clr_pulse (UNDF_rst)
  );

endmodule

// File: tb/tb_timer_apb_regif.sv
// Bench for timer_apb_regif: directed cases plus randomized APB traffic
// against a register-level reference model. A second instance with
// WAIT_CYCLES=2 shares the bus to observe wait-state timing.
module tb_timer_apb_regif;

  localparam logic [7:0] MASK = 8'hB3;

  logic       PCLK = 1'b0;
  logic       RST;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       over_flow, under_flow;

  logic [7:0] PRDATA, TDR, TCR;
  logic       PREADY, PSLVERR, OVF_rst, UNDF_rst;
  logic [1:0] Clk_SEL;

  logic [7:0] w2_PRDATA, w2_TDR, w2_TCR;
  logic       w2_PREADY, w2_PSLVERR, w2_OVF_rst, w2_UNDF_rst;
  logic [1:0] w2_Clk_SEL;

  timer_apb_regif #(.ADDR_W(8), .WAIT_CYCLES(0), .TCR_WMASK(8'hB3)) dut (
    .PCLK(PCLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .over_flow(over_flow), .under_flow(under_flow),
    .TDR(TDR), .TCR(TCR), .Clk_SEL(Clk_SEL), .OVF_rst(OVF_rst), .UNDF_rst(UNDF_rst)
  );

  timer_apb_regif #(.ADDR_W(8), .WAIT_CYCLES(2), .TCR_WMASK(8'hB3)) dut_w2 (
    .PCLK(PCLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(w2_PRDATA), .PREADY(w2_PREADY),
    .PSLVERR(w2_PSLVERR), .over_flow(over_flow), .under_flow(under_flow),
    .TDR(w2_TDR), .TCR(w2_TCR), .Clk_SEL(w2_Clk_SEL), .OVF_rst(w2_OVF_rst),
    .UNDF_rst(w2_UNDF_rst)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int ovf_cnt = 0;
  int udf_cnt = 0;

  // reference model state
  logic [7:0] m_tdr, m_tcr;
  logic [1:0] m_tsr;
  bit         m_ovf_prev, m_udf_prev;

  always @(negedge PCLK) begin
    if (OVF_rst)  ovf_cnt++;
    if (UNDF_rst) udf_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic bit exp_err(input bit wr, input logic [1:0] a, input logic [7:0] d);
    bit e;
    e = (a == 2'd3) || (wr && (a == 2'd1) && ((d & ~MASK) != 8'h00));
`ifndef TIMER_REGIF_PSLVERR_EN
    e = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [7:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_tdr;
      2'd1:    return m_tcr;
      2'd2:    return {6'b0, m_tsr};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [1:0] a, input logic [7:0] d);
    if (exp_err(1'b1, a, d)) return;
    case (a)
      2'd0: m_tdr = d;
      2'd1: m_tcr = d & MASK;
      2'd2: m_tsr = m_tsr & ~d[1:0];
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 2'b00;
    m_ovf_prev = over_flow; m_udf_prev = under_flow;
  endtask

  task automatic drive_flags(input bit o, input bit u);
    @(negedge PCLK);
    over_flow  = o;
    under_flow = u;
    if (o && !m_ovf_prev) m_tsr[0] = 1'b1;
    if (u && !m_udf_prev) m_tsr[1] = 1'b1;
    m_ovf_prev = o;
    m_udf_prev = u;
    @(negedge PCLK);
  endtask

  task automatic apb_xfer(input bit wr, input logic [1:0] a, input logic [7:0] d,
                          input bit use_w2, input bit uf_at_commit,
                          output logic [7:0] rd, output logic err, output int lat);
    bit seen;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PWDATA = d;
    PADDR = 8'($urandom); PADDR[1:0] = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    lat = 0; seen = 1'b0; rd = 8'h00; err = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge PCLK);
      lat++;
      if (use_w2 ? w2_PREADY : PREADY) begin
        seen = 1'b1;
        rd   = use_w2 ? w2_PRDATA : PRDATA;
        err  = use_w2 ? w2_PSLVERR : PSLVERR;
        if (uf_at_commit) under_flow = 1'b1;
      end
    end
    if (!seen) check_eq("pready_timeout", 32'd0, 32'd1);
    @(negedge PCLK);
    check_eq("pready_one_cycle", use_w2 ? w2_PREADY : PREADY, 1'b0);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_op(input bit wr, input logic [1:0] a, input logic [7:0] d);
    int o0, u0, lat;
    logic [7:0] rd, want_rd;
    logic er;
    bit ee;
    int want_o, want_u;
    o0 = ovf_cnt; u0 = udf_cnt;
    want_rd = model_read(a);
    ee      = exp_err(wr, a, d);
    want_o  = (wr && a == 2'd2) ? int'(d[0]) : 0;
    want_u  = (wr && a == 2'd2) ? int'(d[1]) : 0;
    apb_xfer(wr, a, d, 1'b0, 1'b0, rd, er, lat);
    @(negedge PCLK);
    check_eq("latency", lat, 1);
    check_eq("pslverr", er, ee);
    if (!wr) check_eq($sformatf("rdata_a%0d", a), rd, want_rd);
    if (wr) model_write(a, d);
    check_eq("ovf_rst_pulses", ovf_cnt - o0, want_o);
    check_eq("undf_rst_pulses", udf_cnt - u0, want_u);
    check_eq("tdr_port", TDR, m_tdr);
    check_eq("tcr_port", TCR, m_tcr);
    check_eq("clk_sel", Clk_SEL, m_tcr[1:0]);
  endtask

  initial begin
    logic [7:0] rd;
    logic er;
    int lat, u0;

    RST = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 8'h00; over_flow = 1'b0; under_flow = 1'b0;
    model_reset();
    repeat (3) @(negedge PCLK);
    check_eq("rst_tdr", TDR, 8'h00);
    check_eq("rst_tcr", TCR, 8'h00);
    check_eq("rst_prdata", PRDATA, 8'h00);
    check_eq("rst_pready", PREADY, 1'b0);
    check_eq("rst_pslverr", PSLVERR, 1'b0);
    check_eq("rst_ovf_rst", OVF_rst, 1'b0);
    check_eq("rst_undf_rst", UNDF_rst, 1'b0);
    RST = 1'b0;

    // TDR write / readback
    do_op(1'b1, 2'd0, 8'h5A);
    do_op(1'b0, 2'd0, 8'h00);

    // wait-state instance: PREADY in the third access cycle
    apb_xfer(1'b1, 2'd0, 8'h3C, 1'b1, 1'b0, rd, er, lat);
    model_write(2'd0, 8'h3C);
    @(negedge PCLK);
    check_eq("w2_write_latency", lat, 3);
    check_eq("w2_tdr_port", w2_TDR, 8'h3C);
    apb_xfer(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, rd, er, lat);
    check_eq("w2_read_latency", lat, 3);
    check_eq("w2_rdata", rd, 8'h3C);

    // TCR masking (or error with the feature enabled)
    do_op(1'b1, 2'd1, 8'hFF);
    do_op(1'b0, 2'd1, 8'h00);
    do_op(1'b1, 2'd1, 8'h92);
    do_op(1'b0, 2'd1, 8'h00);

    // overflow capture and W1C
    drive_flags(1'b1, 1'b0);
    do_op(1'b0, 2'd2, 8'h00);
    do_op(1'b1, 2'd2, 8'h00);
    do_op(1'b0, 2'd2, 8'h00);
    do_op(1'b1, 2'd2, 8'h01);
    do_op(1'b0, 2'd2, 8'h00);
    drive_flags(1'b0, 1'b0);

    // underflow rising edge coincident with a W1C commit: set wins
    drive_flags(1'b0, 1'b1);
    drive_flags(1'b0, 1'b0);
    u0 = udf_cnt;
    apb_xfer(1'b1, 2'd2, 8'h02, 1'b0, 1'b1, rd, er, lat);
    model_write(2'd2, 8'h02);
    m_tsr[1] = 1'b1;
    m_udf_prev = 1'b1;
    @(negedge PCLK);
    check_eq("coincident_undf_pulses", udf_cnt - u0, 1);
    do_op(1'b0, 2'd2, 8'h00);
    drive_flags(1'b0, 1'b0);

    // reset asserted during the access phase of a TDR write
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h77;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    RST = 1'b1;
    #1;
    check_eq("midrst_pready", PREADY, 1'b0);
    check_eq("midrst_tdr", TDR, 8'h00);
    check_eq("midrst_tcr", TCR, 8'h00);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    RST = 1'b0;
    model_reset();
    do_op(1'b0, 2'd0, 8'h00);
    do_op(1'b0, 2'd2, 8'h00);

    // reserved address
    do_op(1'b1, 2'd0, 8'hC3);
    do_op(1'b1, 2'd3, 8'hFF);
    do_op(1'b0, 2'd3, 8'h00);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0)
        drive_flags(1'($urandom), 1'($urandom));
      do_op(1'($urandom), 2'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_apb_regif.md
Name: timer_apb_regif

Overview:
- APB slave register interface that is the host-facing end of the 8-bit timer.
- Decodes APB writes into the TDR and TCR control registers, and drives Clk_SEL and the OVF_rst/UNDF_rst pulses into the TCNT datapath.
- Captures the counter's over_flow/under_flow status into a sticky TSR register. Software reads TSR and clears it with write-1-to-clear.

Parameters:
- ADDR_W, 8, APB address width; only PADDR[1:0] is decoded.
- WAIT_CYCLES, 0, extra ACCESS-phase cycles before PREADY=1 (0..7).
- TCR_WMASK, 8'hB3, writable TCR bits; masked bits always read 0.

Ports:
- PCLK  in  1  system clock; all flops rise on posedge.
- RST  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  register address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data, valid when PREADY=1.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response (see Optional Feature).
- over_flow  in  1  level flag from the comparison stage.
- under_flow  in  1  level flag from the comparison stage.
- TDR  out  8  timer data register.
- TCR  out  8  timer control register ([7] load mode, [5] down, [4] enable, [1:0] clock select).
- Clk_SEL  out  2  equals TCR[1:0].
- OVF_rst  out  1  one-cycle clear pulse to the overflow flag.
- UNDF_rst  out  1  one-cycle clear pulse to the underflow flag.

Behaviour:
- Reset (async, RST=1): TDR=8'h00, TCR=8'h00, TSR=8'h00, PRDATA=8'h00, PREADY=0, PSLVERR=0, OVF_rst=0, UNDF_rst=0, FSM=IDLE, wait counter=0.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP when PSEL=1 && PENABLE=0.
  - SETUP→ACCESS on the next cycle; PENABLE must be 1 by then.
  - In ACCESS, the wait counter counts up to WAIT_CYCLES. PREADY=1 is registered, high for exactly one cycle, then the FSM goes to IDLE. A back-to-back SETUP goes straight to SETUP.
  - PSEL dropping mid-transfer aborts to IDLE: no register update, no pulse.
- Address map (PADDR[1:0]):
  - 0 = TDR: read/write.
  - 1 = TCR: write value & TCR_WMASK.
  - 2 = TSR: bit0 OVF, bit1 UNDF, bits[7:2] read 0; write-1-to-clear.
  - 3 = reserved: reads 0, writes ignored.
- Write commit happens on the PREADY=1 cycle; register outputs update on the following edge.
- Read data: PRDATA is loaded at the same point PREADY is driven, and holds its value until the next read completes.
- TSR capture: a rising edge of over_flow (registered previous value 0, current 1) sets TSR[0]; under_flow rising edge sets TSR[1].
- W1C: writing TSR with bit0=1 clears TSR[0] and asserts OVF_rst for one PCLK cycle after commit; same for bit1 with UNDF_rst. Bits written as 0 have no effect.
- Simultaneous set and clear on the same edge: set wins, TSR bit stays 1, and the pulse is still issued.
- TCR[4] 1→0 while the counter is running is a plain register write; there is no side effect on TSR.
- Reset asserted mid-transfer forces all of the reset values above immediately; no completion is signalled.

Optional Feature:
- Macro TIMER_REGIF_PSLVERR_EN.
  - Defined: an access to address 3, or any write to a TCR bit outside TCR_WMASK with value 1, completes with PSLVERR=1 in the PREADY cycle, and the write is suppressed entirely.
  - Undefined: PSLVERR is tied 0 and masked bits are silently dropped.

Decomposition:
- Package timer_regif_pkg holds:
  - address constants ADDR_TDR=2'd0, ADDR_TCR=2'd1, ADDR_TSR=2'd2;
  - TCR bit-index constants (LOAD=7, DIR=5, EN=4, CKS=1:0);
  - FSM state enum (IDLE/SETUP/ACCESS).
- One sub-module, timer_flag_capture: edge detect + sticky set/W1C + clear-pulse generation, instantiated twice (OVF, UNDF).

Test Plan:
- Write TDR=8'h5A, then read addr 0 → PRDATA=8'h5A, TDR port=8'h5A, PREADY high exactly one cycle with WAIT_CYCLES=0; with WAIT_CYCLES=2, PREADY rises in the 3rd ACCESS cycle.
- Write TCR=8'hFF → TCR port=8'hB3, Clk_SEL=2'b11, readback 8'hB3. With TIMER_REGIF_PSLVERR_EN defined: PSLVERR=1 and TCR unchanged.
- Pulse over_flow 0→1 → TSR read=8'h01. Write TSR=8'h01 → OVF_rst=1 for one cycle, next read=8'h00. Write TSR=8'h00 leaves it set.
- Under_flow rising edge in the same cycle as a W1C commit of bit1 → TSR[1] stays 1 and UNDF_rst pulses once.
- Assert RST during ACCESS of a TDR write of 8'h77 → TDR=8'h00, PREADY=0, FSM back to IDLE. A subsequent read returns 8'h00.
- Read/write addr 3 → PRDATA=8'h00, no register changes, no OVF_rst/UNDF_rst activity.
